ext_io_wb_responder: RTL
========================

# ext_io_wb_responder

Pipelined Wishbone responder for the SoC's 32-bit external I/O bus (`wb_ext_io`). It terminates the bus inside the debugger SoC with a small register file: ID, control, cycle counter, access counter and scratch words. It provides configurable wait states and stall back-pressure. It replaces the tied-off `wb_ext_io_out` response path and gives firmware a deterministic target for bus and debug bring-up.

## Interface

Parameters:
- `WAIT_STATES`, 1: extra cycles between acceptance and ack. Legal range 0..15.
- `ID_VALUE`, 32'h4D57_4442: read-only value returned at word 0.

Ports:
- `ext_clk`  in  1  single clock for the block.
- `ext_rst`  in  1  reset, synchronous, active-high.
- `wb_ext_io_in_adr`  in  30  word address.
- `wb_ext_io_in_dat`  in  32  write data.
- `wb_ext_io_in_sel`  in  4  byte lane enables.
- `wb_ext_io_in_cyc`  in  1  bus cycle active.
- `wb_ext_io_in_stb`  in  1  request strobe.
- `wb_ext_io_in_we`  in  1  1 = write, 0 = read.
- `wb_ext_io_out_dat`  out  32  read data; valid only while ack is high, 0 otherwise.
- `wb_ext_io_out_ack`  out  1  one-cycle response pulse.
- `wb_ext_io_out_stall`  out  1  back-pressure; a request is not accepted while this is high.
- `ctrl_out`  out  8  current CTRL register value.

## Operation

Acceptance: a request is accepted in a cycle where `cyc & stb & !stall` is true. Each accepted request gets exactly one ack. There are no error or retry responses.

Register map. Word index = `adr[3:0]`. If `adr[29:4] != 0`, reads return 0, writes are ignored, and the request is still acked.
- 0 ID: read-only, returns `ID_VALUE`. Writes are ignored.
- 1 CTRL: read/write, bits[7:0]. Bits[31:8] read as 0. Only `sel[0]` has effect.
- 2 CYCLE: read-only. Free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
- 3 ACCESS: counts accepted requests, 32-bit, wraps. A write of any data with any `sel` clears it to 0.
- 4–15 SCRATCH: read/write, with per-byte `sel` masking.

Commit and capture:
- Writes commit at the acceptance clock edge.
- Read data is captured at the acceptance edge and held until ack.
- A read accepted the cycle after a write returns the new value.
- CYCLE read returns the counter value in the acceptance cycle.
- ACCESS read returns the value before this access's own increment.
- On a write to ACCESS, the clear wins over the increment: the result is 0.
- `sel` = 0 on a write: no state change, still acked.

State machine:
- IDLE: `stall`=0. On acceptance go to WAIT if `WAIT_STATES>0`, else go to ACK.
- WAIT: `stall`=1, counter loaded with `WAIT_STATES`, decrements each cycle. Go to ACK when the counter reaches 1.
- ACK: `ack`=1, `stall`=0, and a new request may be accepted in this cycle (same rules as IDLE). Otherwise return to IDLE.

Abort: if `cyc` falls while in WAIT, return to IDLE next cycle with no ack. A write already committed stays committed.

Reset: `ext_rst` high at any edge, including mid-transaction, forces:
- state IDLE
- `ack`=0, `stall`=0, `dat`=0
- CTRL, CYCLE, ACCESS and all SCRATCH words = 0
- `ctrl_out`=0
- any pending ack is dropped

## Timing

- Accept in cycle T → ack in cycle T+1+`WAIT_STATES`. The ack is high for exactly one cycle.
- Stall is high in cycles T+1 .. T+`WAIT_STATES` and low in the ack cycle.
- `WAIT_STATES`=0:
  - stall is never asserted;
  - sustained throughput is 1 request/cycle;
  - one ack per accepted strobe, in order.
- `WAIT_STATES`=W>0: back-to-back throughput is one request per W+1 cycles. The next acceptance happens in the ack cycle.
- `ctrl_out` updates one cycle after the accepting edge (registered).
- No combinational path from the inputs to `ack` or `dat`. `stall` depends only on state.

## Test plan

1. Reset then ID read, W=1: assert reset 2 cycles, then read adr 0 at T. Required: stall=1 at T+1, ack=1 with dat=0x4D574442 at T+2, `ctrl_out`=0.
2. Scratch byte lanes, W=0: write adr 5 = 0xFFFFFFFF with sel=F, then write 0x12345678 with sel=0101b, then read. Required: reads return 0xFF34FF78, one ack per cycle, stall never high.
3. Back-to-back and ACCESS counter, W=2: hold stb for 4 requests (reads of adr 3). Required:
   - acks at T+3, T+6, T+9, T+12;
   - data 0, 1, 2, 3;
   - a write to adr 3 then a read returns 0.
4. CTRL and out-of-range, W=1: write adr 1 = 0xABCD00A5. Required: `ctrl_out`=0xA5 the cycle after acceptance, and readback = 0x000000A5. Then write/read adr 0x10. Required: acked, read returns 0, no register changes.
5. Abort: W=3, write scratch adr 4 = 0x55, then drop cyc at T+2. Required: no ack, stall=0 by T+3, a later read of adr 4 returns 0x55.
6. Reset mid-transaction and CYCLE wrap, W=3: assert `ext_rst` at T+1 after acceptance. Required: no ack, all outputs 0 next cycle. Then force CYCLE near wrap via long run (or fast-sim override). Required: a read at the 0xFFFFFFFF cycle returns 0xFFFFFFFF, and the next cycle's read returns 0.

Source files
------------

// File: rtl/ext_io_wb_responder.sv
// Wishbone responder terminating the external I/O bus with ID, CTRL,
// CYCLE, ACCESS and SCRATCH registers, configurable wait states and stall.
// Ports: ext_clk/ext_rst (sync, active-high); wb_ext_io_in_* request side;
// wb_ext_io_out_* response side (dat/ack/stall); ctrl_out mirrors CTRL.
module ext_io_wb_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4D57_4442,
  // Reset value of CYCLE; nonzero only to reach the wrap quickly in sim.
  parameter logic [31:0] CYCLE_RST   = 32'h0
) (
  input  logic        ext_clk,
  input  logic        ext_rst,
  input  logic [29:0] wb_ext_io_in_adr,
  input  logic [31:0] wb_ext_io_in_dat,
  input  logic [3:0]  wb_ext_io_in_sel,
  input  logic        wb_ext_io_in_cyc,
  input  logic        wb_ext_io_in_stb,
  input  logic        wb_ext_io_in_we,
  output logic [31:0] wb_ext_io_out_dat,
  output logic        wb_ext_io_out_ack,
  output logic        wb_ext_io_out_stall,
  output logic [7:0]  ctrl_out
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        stall_q, stall_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] access_q, access_d;
  logic [31:0] scr_q [12];
  logic [31:0] scr_d [12];

  logic        accept;
  logic        in_range;
  logic [3:0]  idx;
  logic        wr;
  logic [31:0] wmask;
  logic [31:0] rd_val;

  // Stall is registered from the state, so acceptance never
  // depends combinationally on itself.
  assign accept   = wb_ext_io_in_cyc & wb_ext_io_in_stb & ~stall_q;
  assign in_range = (wb_ext_io_in_adr[29:4] == 26'd0);
  assign idx      = wb_ext_io_in_adr[3:0];
  assign wr       = accept & wb_ext_io_in_we & in_range
                  & (wb_ext_io_in_sel != 4'd0);
  assign wmask    = {{8{wb_ext_io_in_sel[3]}},
                     {8{wb_ext_io_in_sel[2]}},
                     {8{wb_ext_io_in_sel[1]}},
                     {8{wb_ext_io_in_sel[0]}}};

  // Read value seen at the acceptance edge (pre-commit state).
  always_comb begin
    rd_val = 32'd0;
    if (in_range && !wb_ext_io_in_we) begin
      case (idx)
        4'd0:    rd_val = ID_VALUE;
        4'd1:    rd_val = {24'd0, ctrl_q};
        4'd2:    rd_val = cycle_q;
        4'd3:    rd_val = access_q;
        default: rd_val = scr_q[idx - 4'd4];
      endcase
    end
  end

  // Protocol state machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_ACK: begin
        if (accept) begin
          if (WS == 4'd0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!wb_ext_io_in_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered bus outputs.
  always_comb begin
    ack_d   = (state_d == S_ACK);
    stall_d = (state_d == S_WAIT);
    hold_d  = accept ? rd_val : hold_q;
    dat_d   = 32'd0;
    if (state_d == S_ACK) begin
      dat_d = (state_q == S_WAIT) ? hold_q : rd_val;
    end
  end

  // Register file updates; writes commit at the acceptance edge.
  always_comb begin
    ctrl_d  = ctrl_q;
    cycle_d = cycle_q + 32'd1;
    if (wr && idx == 4'd1 && wb_ext_io_in_sel[0]) begin
      ctrl_d = wb_ext_io_in_dat[7:0];
    end
    // A clearing write takes priority over its own count.
    access_d = access_q;
    if (wr && idx == 4'd3) begin
      access_d = 32'd0;
    end else if (accept) begin
      access_d = access_q + 32'd1;
    end
    for (int i = 0; i < 12; i++) begin
      scr_d[i] = scr_q[i];
      if (wr && idx == 4'(i + 4)) begin
        scr_d[i] = (scr_q[i] & ~wmask)
                 | (wb_ext_io_in_dat & wmask);
      end
    end
  end

  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      ack_q    <= 1'b0;
      stall_q  <= 1'b0;
      dat_q    <= 32'd0;
      hold_q   <= 32'd0;
      ctrl_q   <= 8'd0;
      cycle_q  <= CYCLE_RST;
      access_q <= 32'd0;
      for (int i = 0; i < 12; i++) begin
        scr_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      stall_q  <= stall_d;
      dat_q    <= dat_d;
      hold_q   <= hold_d;
      ctrl_q   <= ctrl_d;
      cycle_q  <= cycle_d;
      access_q <= access_d;
      for (int i = 0; i < 12; i++) begin
        scr_q[i] <= scr_d[i];
      end
    end
  end

  assign wb_ext_io_out_dat   = dat_q;
  assign wb_ext_io_out_ack   = ack_q;
  assign wb_ext_io_out_stall = stall_q;
  assign ctrl_out            = ctrl_q;

endmodule
